// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   pc_state_t               : PC generator FSM states (BOOT, RUN, HOLD)
//   DEFAULT_RESET_VECTOR     : first fetch address after reset
//   DEFAULT_EXC_VECTOR       : exception handler entry address
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational redirect selection for the PC generator.
// Picks the redirect source by priority (exception > branch > jump > pending),
// clears the low ALIGN_BITS of the chosen target and flags a misaligned
// request. It also presents the branch/jump target that a stalled pipeline
// should park in the pending register.
//
// Ports:
//   exception       in  : redirect to EXC_VECTOR
//   branch_taken    in  : branch redirect request
//   branch_target   in  : branch destination (raw)
//   jump            in  : jump redirect request
//   jump_target     in  : jump destination (raw)
//   pend_valid      in  : a parked target is waiting
//   pend_target     in  : parked destination (raw)
//   capture_valid   out : a branch or jump is requested this cycle
//   capture_target  out : raw branch/jump target, branch wins
//   redirect        out : some redirect source is active
//   target          out : aligned redirect target
//   target_misalign out : raw redirect target had nonzero low bits
module pc_redirect_sel
    import mips_pkg::*;
#(
    parameter int unsigned           WIDTH      = 32,
    parameter int unsigned           ALIGN_BITS = 2,
    parameter logic [WIDTH-1:0]      EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR)
) (
    input  logic             exception,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             pend_valid,
    input  logic [WIDTH-1:0] pend_target,
    output logic             capture_valid,
    output logic [WIDTH-1:0] capture_target,
    output logic             redirect,
    output logic [WIDTH-1:0] target,
    output logic             target_misalign
);

    // Ones in every bit position that survives alignment.
    localparam logic [WIDTH-1:0] ALIGN_MASK =
        ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));

    logic [WIDTH-1:0] raw_target;

    always_comb begin
        capture_valid  = branch_taken | jump;
        capture_target = branch_taken ? branch_target : jump_target;

        redirect   = 1'b1;
        raw_target = EXC_VECTOR;
        if (exception) begin
            raw_target = EXC_VECTOR;
        end else if (capture_valid) begin
            raw_target = capture_target;
        end else if (pend_valid) begin
            raw_target = pend_target;
        end else begin
            redirect   = 1'b0;
            raw_target = '0;
        end

        target          = raw_target & ALIGN_MASK;
        target_misalign = redirect & (|(raw_target & ~ALIGN_MASK));
    end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator.
// Produces the fetch address stream: one BOOT cycle at RESET_VECTOR, then
// sequential STEP increments, one-cycle-latency redirects for exceptions,
// branches and jumps, and a pending slot that parks a branch/jump target
// while the pipeline is stalled (or while booting).
//
// Ports:
//   clk            in  : clock, rising edge
//   reset          in  : asynchronous active-high reset
//   stall          in  : hold current PC
//   branch_taken   in  : redirect to branch_target
//   branch_target  in  : branch destination
//   jump           in  : redirect to jump_target
//   jump_target    in  : jump/jr destination
//   exception      in  : redirect to EXC_VECTOR, not held off by stall
//   ia             out : current fetch address
//   ia_valid       out : ia is a real fetch address
//   misaligned     out : one-cycle pulse alongside a misaligned redirect load
module pc_gen
    import mips_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
    parameter int unsigned      STEP         = 4,
    parameter int unsigned      ALIGN_BITS   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exception,
    output logic [WIDTH-1:0] ia,
    output logic             ia_valid,
    output logic             misaligned
);

    pc_state_t        state;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_target;

    logic             capture_valid;
    logic [WIDTH-1:0] capture_target;
    logic             redirect;
    logic [WIDTH-1:0] sel_target;
    logic             sel_misalign;

    pc_redirect_sel #(
        .WIDTH      (WIDTH),
        .ALIGN_BITS (ALIGN_BITS),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_sel (
        .exception       (exception),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .pend_valid      (pend_valid),
        .pend_target     (pend_target),
        .capture_valid   (capture_valid),
        .capture_target  (capture_target),
        .redirect        (redirect),
        .target          (sel_target),
        .target_misalign (sel_misalign)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            ia          <= RESET_VECTOR;
            ia_valid    <= 1'b0;
            misaligned  <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            // Every edge out of reset leaves BOOT, so ia is real from here on.
            ia_valid   <= 1'b1;
            misaligned <= 1'b0;

            if (exception) begin
                // Exception overrides stall and drops any parked target.
                ia         <= sel_target;
                misaligned <= sel_misalign;
                pend_valid <= 1'b0;
                state      <= stall ? HOLD : RUN;
            end else if (stall || state == BOOT) begin
                // ia is frozen; park any branch/jump, newest wins.
                if (capture_valid) begin
                    pend_valid  <= 1'b1;
                    pend_target <= capture_target;
                end
                state <= stall ? HOLD : RUN;
            end else begin
                // RUN or HOLD with stall low: live event, then parked, then step.
                if (redirect) begin
                    ia         <= sel_target;
                    misaligned <= sel_misalign;
                end else begin
                    ia <= ia + WIDTH'(STEP);
                end
                pend_valid <= 1'b0;
                state      <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen at default parameters.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;
    logic [31:0] ia;
    logic        ia_valid;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exception     (exception),
        .ia            (ia),
        .ia_valid      (ia_valid),
        .misaligned    (misaligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        exception     = 1'b0;
    endtask

    task automatic check_pc(input string tag, input logic [31:0] exp_ia,
                            input logic exp_valid, input logic exp_mis);
        check({tag, ".ia"}, ia, exp_ia);
        check({tag, ".valid"}, {31'd0, ia_valid}, {31'd0, exp_valid});
        check({tag, ".mis"}, {31'd0, misaligned}, {31'd0, exp_mis});
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        check_pc("in_reset", 32'h8000_0000, 1'b0, 1'b0);
        tick();
        tick();

        // Release between edges; the next edge ends BOOT.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_pc("boot", 32'h8000_0000, 1'b0, 1'b0);
        tick();
        check_pc("run0", 32'h8000_0000, 1'b1, 1'b0);
        tick();
        check("run1", ia, 32'h8000_0004);
        tick();
        check("run2", ia, 32'h8000_0008);
        tick();
        check("run3", ia, 32'h8000_000C);
        tick();
        check("run4", ia, 32'h8000_0010);

        // Branch beats jump in the same cycle.
        branch_taken  = 1'b1;
        branch_target = 32'h8000_0100;
        jump          = 1'b1;
        jump_target   = 32'h8000_0400;
        tick();
        idle_inputs();
        check_pc("br_over_jmp", 32'h8000_0100, 1'b1, 1'b0);

        // Move to 0x80000020, then a 3-cycle stall with a misaligned jump.
        jump        = 1'b1;
        jump_target = 32'h8000_0020;
        tick();
        idle_inputs();
        check("jmp_20", ia, 32'h8000_0020);
        stall = 1'b1;
        tick();
        check("stall1", ia, 32'h8000_0020);
        jump        = 1'b1;
        jump_target = 32'h8000_0203;
        tick();
        jump = 1'b0;
        check_pc("stall2", 32'h8000_0020, 1'b1, 1'b0);
        tick();
        check("stall3", ia, 32'h8000_0020);
        stall = 1'b0;
        tick();
        check_pc("pend_load", 32'h8000_0200, 1'b1, 1'b1);
        tick();
        check_pc("after_pend", 32'h8000_0204, 1'b1, 1'b0);

        // Exception during stall clears a parked branch.
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h8000_0300;
        tick();
        branch_taken = 1'b0;
        check("stall_br", ia, 32'h8000_0204);
        exception = 1'b1;
        tick();
        exception = 1'b0;
        check("exc_stall", ia, 32'h8000_0180);
        tick();
        check("exc_hold", ia, 32'h8000_0180);
        stall = 1'b0;
        tick();
        check("exc_release", ia, 32'h8000_0184);

        // Later jump during the same stall overwrites an earlier branch.
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h8000_0500;
        tick();
        branch_taken = 1'b0;
        jump         = 1'b1;
        jump_target  = 32'h8000_0600;
        tick();
        idle_inputs();
        check("ovr_held", ia, 32'h8000_0184);
        tick();
        check("ovr_load", ia, 32'h8000_0600);

        // Exception beats branch in the same cycle.
        exception     = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h8000_0700;
        tick();
        idle_inputs();
        check("exc_over_br", ia, 32'h8000_0180);

        // Wrap at the top of the address space.
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        check("wrap_top", ia, 32'hFFFF_FFFC);
        tick();
        check("wrap_zero", ia, 32'h0000_0000);
        tick();
        check("wrap_next", ia, 32'h0000_0004);

        // Asynchronous reset mid-HOLD with a parked branch.
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h8000_0700;
        tick();
        branch_taken = 1'b0;
        check("hold_pre_rst", ia, 32'h0000_0004);
        #2;
        reset = 1'b1;
        #1;
        check_pc("async_rst", 32'h8000_0000, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        tick();
        check_pc("boot_stall", 32'h8000_0000, 1'b1, 1'b0);
        stall = 1'b0;
        tick();
        check("no_stale_pend", ia, 32'h8000_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
